bram_block_queue: RTL
=====================

BRAM_BLOCK_QUEUE -- requirements
Module: bram_block_queue

Interface
REQ-001 SHALL have parameter BLOCK_NUM_INDEX, default 6, meaning log2 of the block count (64 blocks).
REQ-002 SHALL have parameter BLOCK_DEPTH_INDEX, default 9, meaning log2 of the words per block (512).
REQ-003 SHALL have parameter BLOCK_WIDTH, default 32, meaning word width in bits.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port wr_valid, input, 1, meaning the write word is offered.
REQ-007 SHALL have port wr_ready, output, 1, meaning the write word is accepted this cycle.
REQ-008 SHALL have port wr_data, input, BLOCK_WIDTH, meaning the write word.
REQ-009 SHALL have port rd_block_avail, output, 1, meaning at least one committed block is readable.
REQ-010 SHALL have port rd_en, input, 1, meaning a read of the head block.
REQ-011 SHALL have port rd_addr, input, BLOCK_DEPTH_INDEX, meaning the word offset within the head block.
REQ-012 SHALL have port rd_data, output, BLOCK_WIDTH, meaning the read word.
REQ-013 SHALL have port rd_data_valid, output, 1, meaning rd_data holds a read result.
REQ-014 SHALL have port rd_release, input, 1, meaning a pulse that frees the head block.
REQ-015 SHALL have port blocks_used, output, BLOCK_NUM_INDEX+1, meaning the committed block count.

Function
REQ-016 SHALL be a circular queue of 2^BLOCK_NUM_INDEX blocks, each 2^BLOCK_DEPTH_INDEX words.
REQ-017 SHALL hold wr_ready = (blocks_used < 2^BLOCK_NUM_INDEX); a write occurs when wr_valid && wr_ready.
REQ-018 SHALL store each write at {wr_blk_ptr, wr_word_cnt} and then increment wr_word_cnt.
REQ-019 SHALL, on the write of word 2^BLOCK_DEPTH_INDEX-1, commit the block: wr_word_cnt wraps to 0, wr_blk_ptr increments modulo the block count, and blocks_used increments.
REQ-020 SHALL hold rd_block_avail = (blocks_used != 0).
REQ-021 SHALL, on rd_en with rd_block_avail=1, register memory[{rd_blk_ptr, rd_addr}] into rd_data and assert rd_data_valid for exactly one cycle (latency 1).
REQ-022 SHALL ignore rd_en when rd_block_avail=0, keeping rd_data_valid=0 and rd_data unchanged.
REQ-023 SHALL, on rd_release with rd_block_avail=1, increment rd_blk_ptr modulo the block count and decrement blocks_used.
REQ-024 SHALL ignore rd_release when rd_block_avail=0.
REQ-025 SHALL leave blocks_used unchanged when a commit and a valid release occur in the same cycle, while both pointers advance.
REQ-026 SHALL, when rd_en and rd_release occur in the same cycle, return the read from the pre-release head block.
REQ-027 SHALL never let the writer address a committed block, so no read/write collision on the same word is possible.
REQ-028 SHALL keep a partially filled block invisible to the reader.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously clear wr_blk_ptr, wr_word_cnt, rd_blk_ptr, blocks_used, rd_data and rd_data_valid to 0, which makes wr_ready=1 and rd_block_avail=0.
REQ-030 SHALL NOT reset memory contents, and SHALL discard any partially written block when reset asserts mid-operation.

Structure
REQ-031 SHALL take parameter defaults and derived widths (BLOCK_INDEX = BLOCK_NUM_INDEX + BLOCK_DEPTH_INDEX) from shared package bram_pkg.
REQ-032 SHALL instantiate one sub-module, bram_sdp: simple dual-port memory of 2^BLOCK_INDEX x BLOCK_WIDTH, with synchronous write and registered read, suitable for BRAM inference.

Verification
All scenarios use BLOCK_NUM_INDEX=2, BLOCK_DEPTH_INDEX=2, BLOCK_WIDTH=8.
REQ-033 SHALL cover fill and read: write 0x10..0x13, then at 0x13 the next cycle shows blocks_used=1 and rd_block_avail=1; rd_en with rd_addr=2 gives rd_data=0x12 and rd_data_valid=1 one cycle later.
REQ-034 SHALL cover full: write 16 words with no release, giving blocks_used=4 and wr_ready=0; a 17th wr_valid is not accepted and memory is unchanged.
REQ-035 SHALL cover wrap: a full queue plus 4 releases and 4 more words written gives wr_blk_ptr wrapping to block 0, and block 0 reads the new data.
REQ-036 SHALL cover a simultaneous commit and release with blocks_used=2 before the edge: blocks_used=2 after the edge and both pointers advance by 1.
REQ-037 SHALL cover an empty queue: rd_en and rd_release with blocks_used=0 give rd_data_valid=0, blocks_used=0 and rd_blk_ptr=0.
REQ-038 SHALL cover reset mid-block: 2 words written, then rst_n pulsed low for one cycle; afterwards blocks_used=0, wr_ready=1, and the next 4 writes form block 0.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared defaults and derived widths for the block-queue memory slice.
package bram_pkg;

    localparam int BLOCK_NUM_INDEX_DEF   = 6;
    localparam int BLOCK_DEPTH_INDEX_DEF = 9;
    localparam int BLOCK_WIDTH_DEF       = 32;

    // Flat memory address width: block pointer concatenated with word offset.
    function automatic int block_index(input int num_index, input int depth_index);
        return num_index + depth_index;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module bram_sdp
    import bram_pkg::*;
#(
    parameter int ADDR_W = block_index(BLOCK_NUM_INDEX_DEF, BLOCK_DEPTH_INDEX_DEF),
    parameter int DATA_W = BLOCK_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // No reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bram_block_queue.sv
// Circular queue of fixed-size blocks: the writer fills whole blocks, the reader
// randomly accesses the oldest committed block and releases it when done.
module bram_block_queue
    import bram_pkg::*;
#(
    parameter int BLOCK_NUM_INDEX   = BLOCK_NUM_INDEX_DEF,
    parameter int BLOCK_DEPTH_INDEX = BLOCK_DEPTH_INDEX_DEF,
    parameter int BLOCK_WIDTH       = BLOCK_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [BLOCK_WIDTH-1:0]       wr_data,
    output logic                         rd_block_avail,
    input  logic                         rd_en,
    input  logic [BLOCK_DEPTH_INDEX-1:0] rd_addr,
    output logic [BLOCK_WIDTH-1:0]       rd_data,
    output logic                         rd_data_valid,
    input  logic                         rd_release,
    output logic [BLOCK_NUM_INDEX:0]     blocks_used
);

    localparam int BLOCK_INDEX = block_index(BLOCK_NUM_INDEX, BLOCK_DEPTH_INDEX);
    localparam logic [BLOCK_NUM_INDEX:0]     FULL_COUNT = {1'b1, {BLOCK_NUM_INDEX{1'b0}}};
    localparam logic [BLOCK_DEPTH_INDEX-1:0] LAST_WORD  = '1;

    logic [BLOCK_NUM_INDEX-1:0]   wr_blk_ptr;
    logic [BLOCK_DEPTH_INDEX-1:0] wr_word_cnt;
    logic [BLOCK_NUM_INDEX-1:0]   rd_blk_ptr;
    logic                         rd_loaded;
    logic [BLOCK_WIDTH-1:0]       mem_rdata;
    logic                         wr_fire;
    logic                         commit;
    logic                         rd_fire;
    logic                         release_fire;

    // Handshakes: a write word transfers on a rising edge where wr_valid && wr_ready;
    // rd_en and rd_release are single-cycle requests honoured only while rd_block_avail.
    assign wr_ready       = (blocks_used < FULL_COUNT);
    assign rd_block_avail = (blocks_used != '0);
    assign wr_fire        = wr_valid && wr_ready;
    assign commit         = wr_fire && (wr_word_cnt == LAST_WORD);
    assign rd_fire        = rd_en && rd_block_avail;
    assign release_fire   = rd_release && rd_block_avail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_blk_ptr    <= '0;
            wr_word_cnt   <= '0;
            rd_blk_ptr    <= '0;
            blocks_used   <= '0;
            rd_data_valid <= 1'b0;
            rd_loaded     <= 1'b0;
        end else begin
            rd_data_valid <= rd_fire;
            if (rd_fire) begin
                rd_loaded <= 1'b1;
            end
            if (wr_fire) begin
                wr_word_cnt <= wr_word_cnt + BLOCK_DEPTH_INDEX'(1);
            end
            if (commit) begin
                wr_blk_ptr <= wr_blk_ptr + BLOCK_NUM_INDEX'(1);
            end
            if (release_fire) begin
                rd_blk_ptr <= rd_blk_ptr + BLOCK_NUM_INDEX'(1);
            end
            if (commit && !release_fire) begin
                blocks_used <= blocks_used + (BLOCK_NUM_INDEX + 1)'(1);
            end else if (release_fire && !commit) begin
                blocks_used <= blocks_used - (BLOCK_NUM_INDEX + 1)'(1);
            end
        end
    end

    // The RAM read register is not resettable; rd_loaded masks it to zero until the first read.
    assign rd_data = rd_loaded ? mem_rdata : '0;

    bram_sdp #(
        .ADDR_W(BLOCK_INDEX),
        .DATA_W(BLOCK_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_fire),
        .waddr({wr_blk_ptr, wr_word_cnt}),
        .wdata(wr_data),
        .re   (rd_fire),
        .raddr({rd_blk_ptr, rd_addr}),
        .rdata(mem_rdata)
    );

endmodule
